// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Round-robin arbiter giving four requesters access to a single memory port.
//   A three-state FSM (IDLE -> BUSY -> RESP) handles one access at a time. All
//   outputs are registered. A programmable timeout ends an access that the
//   memory never answers, and the owner then receives an error pulse.
//
// Parameters
//   TIMEOUT        max BUSY cycles spent waiting for mem_resp (0 = never time out)
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous, active-high reset
//   rd_req[3:0]    per-requester read request (level, held until done/error)
//   wr_req[3:0]    per-requester write request (level, held until done/error)
//   req_addr       four 14-bit addresses, requester i at [14i+13:14i]
//   req_wdata      four 16-bit write words, requester i at [16i+15:16i]
//   gnt[3:0]       one-hot current owner of the memory port
//   done[3:0]      one-hot 1-cycle pulse, owner's access completed
//   error[3:0]     one-hot 1-cycle pulse, owner's access timed out
//   rdata          last word read; valid while done is high, held otherwise
//   mem_read_req   read strobe to memory (level)
//   mem_write_req  write strobe to memory (level)
//   mem_addr       latched address of the owner
//   mem_write_data latched write word during writes, zero otherwise
//   mem_read_data  memory read word, valid with mem_resp
//   mem_resp       memory completion pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rd_req,
  input  logic [3:0]  wr_req,
  input  logic [55:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [3:0]  error,
  output logic [15:0] rdata,
  output logic        mem_read_req,
  output logic        mem_write_req,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_write_data,
  input  logic [15:0] mem_read_data,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);
  localparam bit          TIMEOUT_EN  = (TIMEOUT != 0);

  state_t      state;
  logic [1:0]  ptr;        // round-robin start point for the next search
  logic [1:0]  idx;        // index of the current owner
  logic        is_write;   // operation latched for the current owner
  logic [15:0] busy_cnt;   // cycles already spent in BUSY

  logic [3:0]  pending;
  logic        any_pending;
  logic [1:0]  win;
  logic [15:0] busy_cnt_next;
  logic        timed_out;

  assign pending       = rd_req | wr_req;
  assign busy_cnt_next = busy_cnt + 16'd1;
  // Comparing the incremented count makes an access last exactly TIMEOUT
  // BUSY cycles before the error is raised.
  assign timed_out     = TIMEOUT_EN && (busy_cnt_next == TIMEOUT_VAL);

  // Round-robin search. Offsets are scanned from high to low so the last hit,
  // which is the requester closest to ptr, is the one that sticks.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    any_pending = 1'b0;
    win         = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (pending[ptr + 2'(k)]) begin
        any_pending = 1'b1;
        win         = ptr + 2'(k);
      end
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values and simulation matches hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= 2'd0;
      idx            <= 2'd0;
      is_write       <= 1'b0;
      busy_cnt       <= 16'd0;
      gnt            <= 4'd0;
      done           <= 4'd0;
      error          <= 4'd0;
      rdata          <= 16'd0;
      mem_read_req   <= 1'b0;
      mem_write_req  <= 1'b0;
      mem_addr       <= 14'd0;
      mem_write_data <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_pending) begin
            // A simultaneous read and write from the winner performs the
            // write; the read stays pending for a later turn.
            idx            <= win;
            is_write       <= wr_req[win];
            gnt            <= 4'b0001 << win;
            mem_read_req   <= ~wr_req[win];
            mem_write_req  <= wr_req[win];
            mem_addr       <= req_addr[14*win +: 14];
            mem_write_data <= wr_req[win] ? req_wdata[16*win +: 16] : 16'h0000;
            busy_cnt       <= 16'd0;
            state          <= BUSY;
          end
        end

        BUSY: begin
          busy_cnt <= busy_cnt_next;
          // mem_resp takes priority when it lands on the timeout cycle.
          if (mem_resp || timed_out) begin
            gnt            <= 4'd0;
            mem_read_req   <= 1'b0;
            mem_write_req  <= 1'b0;
            mem_write_data <= 16'h0000;
            if (mem_resp) begin
              done <= 4'b0001 << idx;
              if (!is_write) begin
                rdata <= mem_read_data;
              end
            end else begin
              error <= 4'b0001 << idx;
            end
            state <= RESP;
          end
        end

        RESP: begin
          done  <= 4'd0;
          error <= 4'd0;
          ptr   <= idx + 2'd1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter (TIMEOUT = 8). The bench plays both the
//   four requesters and the memory. A transaction-level reference model picks
//   the round-robin winner from the pending requests with modular arithmetic,
//   derives the access length from the memory latency and timeout, and tracks
//   the expected rdata and round-robin pointer.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rd_req, wr_req;
  logic [55:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  gnt, done, error;
  logic [15:0] rdata, mem_write_data, mem_read_data;
  logic        mem_read_req, mem_write_req, mem_resp;
  logic [13:0] mem_addr;

  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  m_ptr;      // model: round-robin start point
  logic [15:0] m_rdata;    // model: last word read

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .rd_req         (rd_req),
    .wr_req         (wr_req),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .gnt            (gnt),
    .done           (done),
    .error          (error),
    .rdata          (rdata),
    .mem_read_req   (mem_read_req),
    .mem_write_req  (mem_write_req),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_resp       (mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [13:0] a, input logic [15:0] d);
    req_addr[14*i +: 14]  = a;
    req_wdata[16*i +: 16] = d;
  endtask

  // Requester i (not the owner) raises a fresh request while an access runs.
  task automatic raise_other(input logic [1:0] owner);
    int i;
    int op;
    i  = $urandom_range(0, 3);
    op = $urandom_range(1, 3);
    if (i != int'(owner) && !rd_req[i] && !wr_req[i]) begin
      set_req(i, 14'($urandom), 16'($urandom));
      rd_req[i] = op[0];
      wr_req[i] = op[1];
    end
  endtask

  // One arbitration turn, starting in an IDLE cycle with inputs already set.
  // lat: memory answers in BUSY cycle lat+1 (unless the timeout comes first).
  task automatic do_access(input int lat, input logic [15:0] rdat,
                           input bit drop, input bit churn);
    logic [3:0]  pend;
    logic [1:0]  w;
    logic [3:0]  oh;
    logic [13:0] a;
    logic [15:0] wd;
    bit          found, is_wr, to;
    int          c, j, busy_len;

    pend  = rd_req | wr_req;
    found = 1'b0;
    w     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      c = (int'(m_ptr) + k) % 4;
      if (!found && pend[c]) begin
        found = 1'b1;
        w     = 2'(c);
      end
    end

    mem_resp = churn ? 1'($urandom_range(0, 1)) : 1'b0;
    if (!found) begin
      tick;
      mem_resp = 1'b0;
      n_vec++;
      if ({gnt, done, error, mem_read_req, mem_write_req} !== 14'd0) begin
        n_err++;
        $display("FAIL idle_hold: gnt=%b done=%b error=%b rd=%b wr=%b, want all 0",
                 gnt, done, error, mem_read_req, mem_write_req);
      end
      return;
    end

    is_wr    = wr_req[w];
    a        = req_addr[14*w +: 14];
    wd       = req_wdata[16*w +: 16];
    oh       = 4'b0001 << w;
    j        = lat + 1;
    to       = (TO != 0) && (j > TO);
    busy_len = to ? TO : j;

    tick;
    mem_resp = 1'b0;
    for (int cyc = 1; cyc <= busy_len; cyc++) begin
      n_vec++;
      if ({gnt, mem_read_req, mem_write_req, mem_addr, mem_write_data, done, error}
          !== {oh, !is_wr, is_wr, a, (is_wr ? wd : 16'h0000), 8'h00}) begin
        n_err++;
        $display("FAIL busy_cycle%0d: got gnt=%b rd=%b wr=%b addr=%h wdata=%h done=%b err=%b; want gnt=%b rd=%b wr=%b addr=%h wdata=%h done=0 err=0",
                 cyc, gnt, mem_read_req, mem_write_req, mem_addr, mem_write_data, done, error,
                 oh, !is_wr, is_wr, a, (is_wr ? wd : 16'h0000));
      end
      mem_resp      = (cyc == j);
      mem_read_data = (cyc == j) ? rdat : 16'($urandom);
      if (churn && $urandom_range(0, 3) == 0) raise_other(w);
      tick;
    end
    mem_resp = 1'b0;

    if (!to && !is_wr) m_rdata = rdat;
    n_vec++;
    if ({gnt, mem_read_req, mem_write_req, mem_write_data, done, error, rdata}
        !== {4'h0, 1'b0, 1'b0, 16'h0000, (to ? 4'h0 : oh), (to ? oh : 4'h0), m_rdata}) begin
      n_err++;
      $display("FAIL resp_cycle: got gnt=%b rd=%b wr=%b wdata=%h done=%b err=%b rdata=%h; want gnt=0 rd=0 wr=0 wdata=0 done=%b err=%b rdata=%h",
               gnt, mem_read_req, mem_write_req, mem_write_data, done, error, rdata,
               (to ? 4'h0 : oh), (to ? oh : 4'h0), m_rdata);
    end

    if (drop) begin
      if (is_wr) wr_req[w] = 1'b0;
      else       rd_req[w] = 1'b0;
    end
    m_ptr    = w + 2'd1;
    mem_resp = churn ? 1'($urandom_range(0, 1)) : 1'b0;
    tick;
    mem_resp = 1'b0;

    n_vec++;
    if ({gnt, done, error, mem_read_req, mem_write_req, rdata}
        !== {12'h000, 1'b0, 1'b0, m_rdata}) begin
      n_err++;
      $display("FAIL after_resp: gnt=%b done=%b err=%b rd=%b wr=%b rdata=%h; want zeros, rdata=%h",
               gnt, done, error, mem_read_req, mem_write_req, rdata, m_rdata);
    end
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    rd_req        = 4'b1111;
    wr_req        = 4'b0101;
    req_addr      = {$urandom, $urandom};
    req_wdata     = {$urandom, $urandom};
    mem_resp      = 1'b1;
    mem_read_data = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({gnt, done, error, rdata, mem_read_req, mem_write_req, mem_addr, mem_write_data} !== 60'd0) begin
      n_err++;
      $display("FAIL reset_state: gnt=%b done=%b err=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h, want all 0",
               gnt, done, error, rdata, mem_read_req, mem_write_req, mem_addr, mem_write_data);
    end
    rd_req   = 4'd0;
    wr_req   = 4'd0;
    mem_resp = 1'b0;
    reset    = 1'b0;
    m_ptr    = 2'd0;
    m_rdata  = 16'd0;
    tick;
    n_vec++;
    if ({gnt, done, error, mem_read_req, mem_write_req} !== 14'd0) begin
      n_err++;
      $display("FAIL post_reset_idle: gnt=%b done=%b err=%b, want 0", gnt, done, error);
    end
  endtask

  task automatic test_round_robin;
    rd_req = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 14'(16'h0100 + i), 16'h0000);
    for (int n = 0; n < 5; n++) do_access(1, 16'(16'h0A00 + n), 1'b0, 1'b0);
    rd_req = 4'd0;
  endtask

  task automatic test_single_read;
    rd_req = 4'b0100;
    set_req(2, 14'h0123, 16'h0000);
    do_access(3, 16'hBEEF, 1'b1, 1'b0);
  endtask

  task automatic test_write;
    wr_req = 4'b0001;
    set_req(0, 14'h3FFF, 16'h5A5A);
    do_access(2, 16'h1234, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_access;
    rd_req = 4'b0100;
    set_req(2, 14'h0AAA, 16'h0000);
    tick;
    tick;
    n_vec++;
    if ({gnt, mem_read_req} !== 5'b0100_1) begin
      n_err++;
      $display("FAIL mid_busy: gnt=%b rd=%b, want gnt=0100 rd=1", gnt, mem_read_req);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({gnt, done, error, rdata, mem_read_req, mem_write_req, mem_addr, mem_write_data} !== 60'd0) begin
      n_err++;
      $display("FAIL async_reset: gnt=%b done=%b err=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h, want all 0",
               gnt, done, error, rdata, mem_read_req, mem_write_req, mem_addr, mem_write_data);
    end
    @(posedge clk); #1;
    mem_resp      = 1'b1;
    mem_read_data = 16'hDEAD;
    @(posedge clk); #1;
    rd_req   = 4'd0;
    reset    = 1'b0;
    m_ptr    = 2'd0;
    m_rdata  = 16'd0;
    tick;
    mem_resp = 1'b0;
    tick;
    n_vec++;
    if ({gnt, done, error, rdata} !== 28'd0) begin
      n_err++;
      $display("FAIL late_resp_ignored: gnt=%b done=%b err=%b rdata=%h, want 0",
               gnt, done, error, rdata);
    end
    rd_req = 4'b0101;
    set_req(0, 14'h0011, 16'h0000);
    set_req(2, 14'h0022, 16'h0000);
    do_access(1, 16'h1111, 1'b1, 1'b0);
    do_access(0, 16'h2222, 1'b1, 1'b0);
  endtask

  task automatic test_timeout;
    rd_req = 4'b1000;
    set_req(3, 14'h2BCD, 16'h0000);
    do_access(100, 16'hCAFE, 1'b1, 1'b0);
    rd_req = 4'b1001;
    set_req(0, 14'h0333, 16'h0000);
    do_access(0, 16'h3030, 1'b1, 1'b0);
    do_access(4, 16'h4040, 1'b1, 1'b0);
  endtask

  task automatic test_rd_wr_collision;
    rd_req = 4'b0110;
    wr_req = 4'b0010;
    set_req(1, 14'h1357, 16'hA5C3);
    set_req(2, 14'h2468, 16'h0000);
    do_access(TO - 1, 16'h7777, 1'b1, 1'b0);
    do_access(2, 16'h8888, 1'b1, 1'b0);
    do_access(5, 16'h9999, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    int op;
    for (int t = 0; t < 120; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!rd_req[i] && !wr_req[i] && $urandom_range(0, 2) == 0) begin
          op = $urandom_range(1, 3);
          set_req(i, 14'($urandom), 16'($urandom));
          rd_req[i] = op[0];
          wr_req[i] = op[1];
        end
      end
      do_access($urandom_range(0, 9), 16'($urandom), 1'b1, 1'b1);
    end
    rd_req = 4'd0;
    wr_req = 4'd0;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single_read;
    test_write;
    test_reset_mid_access;
    test_timeout;
    test_rd_wr_collision;
    test_random;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
